// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width defaults and ALU control encodings for the pipeline.
package riscv_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_RA_W = 5;
  typedef enum logic [DEF_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks one source operand from EX/MEM, MEM/WB or the stored value; x0 always reads 0.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
) (
  input  logic [RA_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_regwrite_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_regwrite_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] data_o
);
  // rs!=0 together with rd==rs already implies rd!=0
  always_comb
    data_o = (rs_addr_i == '0) ? '0 :
             (exmem_regwrite_i && exmem_rd_i == rs_addr_i) ? exmem_data_i :
             (memwb_regwrite_i && memwb_rd_i == rs_addr_i) ? memwb_data_i : rs_data_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register; operand forwarding enabled by ID_EX_FWD_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RA_W = DEF_RA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [RA_W-1:0]   rs1_addr_i,
  input  logic [RA_W-1:0]   rs2_addr_i,
  input  logic [RA_W-1:0]   rd_addr_i,
  input  logic              alu_src_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic              reg_write_i,
  input  logic              flush_i,
  input  logic [RA_W-1:0]   exmem_rd_i,
  input  logic              exmem_regwrite_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic [RA_W-1:0]   memwb_rd_i,
  input  logic              memwb_regwrite_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   data1_o,
  output logic [XLEN-1:0]   data2_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [RA_W-1:0]   rd_addr_o,
  output logic              reg_write_o
);
  logic              valid_q, valid_d, load;
  logic [XLEN-1:0]   rs1_q, rs2_q, imm_q, op1, op2;
  logic [RA_W-1:0]   rs1_addr_q, rs2_addr_q, rd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              alu_src_q, reg_write_q;
  always_comb begin
    load = valid_i && ready_o && !flush_i;
    valid_d = !flush_i && (load || (valid_q && !ready_i));
  end
`ifdef ID_EX_FWD_EN
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_addr_i(rs1_addr_q), .rs_data_i(rs1_q),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i), .memwb_data_i(memwb_data_i),
    .data_o(op1)
  );
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_addr_i(rs2_addr_q), .rs_data_i(rs2_q),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i), .memwb_data_i(memwb_data_i),
    .data_o(op2)
  );
`else
  logic unused_fwd;
  assign op1 = rs1_q;
  assign op2 = rs2_q;
  assign unused_fwd = ^{rs1_addr_q, rs2_addr_q, exmem_rd_i, exmem_regwrite_i, exmem_data_i,
                        memwb_rd_i, memwb_regwrite_i, memwb_data_i};
`endif
  // when not loading, operands take their forwarded value so a held entry never goes stale
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= load ? rs1_data_i : op1;
      rs2_q   <= load ? rs2_data_i : op2;
      if (load) begin
        imm_q       <= imm_i;
        rs1_addr_q  <= rs1_addr_i;
        rs2_addr_q  <= rs2_addr_i;
        rd_q        <= rd_addr_i;
        ctrl_q      <= ALUCtrl_i;
        alu_src_q   <= alu_src_i;
        reg_write_q <= reg_write_i;
      end
    end
  assign ready_o      = !valid_q || ready_i;
  assign valid_o      = valid_q;
  assign data1_o      = op1;
  assign data2_o      = alu_src_q ? imm_q : op2;
  assign store_data_o = op2;
  assign ALUCtrl_o    = ctrl_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = valid_q && reg_write_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus randomized run against a queue-based reference model.
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic rst, valid, ready, flush, alusrc, rw, exrw, wbrw;
    logic [4:0] a1, a2, rd, exrd, wbrd;
    logic [31:0] d1, d2, imm, exd, wbd;
    logic [2:0] ctrl;
  } vin_t;
  typedef struct {
    bit chk, vo, ro, rwo;
    logic [31:0] d1, d2, sd;
    logic [2:0] c;
    logic [4:0] rd;
  } exp_t;
  typedef struct {
    vin_t i;
    exp_t e;
  } vec_t;
  typedef struct {
    logic [4:0] a1, a2, rd;
    logic [31:0] v1, v2, imm;
    logic alusrc, rw;
    logic [2:0] ctrl;
  } entry_t;
  logic clk = 1'b0, rst, valid_i, ready_o, alu_src_i, reg_write_i, flush_i;
  logic exmem_regwrite_i, memwb_regwrite_i, valid_o, ready_i, reg_write_o;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, exmem_data_i, memwb_data_i;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i, exmem_rd_i, memwb_rd_i, rd_addr_o;
  logic [2:0] ALUCtrl_i, ALUCtrl_o;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[$];
  entry_t q[$];
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_src_i(alu_src_i), .ALUCtrl_i(ALUCtrl_i), .reg_write_i(reg_write_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i), .memwb_data_i(memwb_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data1_o(data1_o), .data2_o(data2_o),
    .ALUCtrl_o(ALUCtrl_o), .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o)
  );
  function automatic vin_t idle();
    vin_t i;
    i = '{rst: 1, ready: 1, default: '0};
    return i;
  endfunction
  function automatic exp_t ev(bit vo, bit ro, bit rwo);
    exp_t e;
    e = '{chk: 0, vo: vo, ro: ro, rwo: rwo, default: '0};
    return e;
  endfunction
  function automatic exp_t ed(bit vo, bit ro, bit rwo, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] sd, logic [2:0] c, logic [4:0] rd);
    exp_t e;
    e = '{chk: 1, vo: vo, ro: ro, rwo: rwo, d1: d1, d2: d2, sd: sd, c: c, rd: rd};
    return e;
  endfunction
  function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] v, vin_t i);
    if (!FWD) return v;
    if (a == 0) return 0;
    if (i.exrw && i.exrd == a) return i.exd;
    if (i.wbrw && i.wbrd == a) return i.wbd;
    return v;
  endfunction
  task automatic add(vin_t i, exp_t e);
    tbl.push_back('{i: i, e: e});
  endtask
  task automatic apply(vin_t i);
    rst = i.rst; valid_i = i.valid; ready_i = i.ready; flush_i = i.flush;
    alu_src_i = i.alusrc; reg_write_i = i.rw; ALUCtrl_i = i.ctrl;
    rs1_addr_i = i.a1; rs2_addr_i = i.a2; rd_addr_i = i.rd;
    rs1_data_i = i.d1; rs2_data_i = i.d2; imm_i = i.imm;
    exmem_rd_i = i.exrd; exmem_regwrite_i = i.exrw; exmem_data_i = i.exd;
    memwb_rd_i = i.wbrd; memwb_regwrite_i = i.wbrw; memwb_data_i = i.wbd;
  endtask
  task automatic check(string nm, exp_t e);
    bit bad;
    n_vec++;
    bad = valid_o !== e.vo || ready_o !== e.ro || reg_write_o !== e.rwo;
    if (e.chk)
      bad = bad || data1_o !== e.d1 || data2_o !== e.d2 || store_data_o !== e.sd ||
            ALUCtrl_o !== e.c || rd_addr_o !== e.rd;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got v=%b r=%b rw=%b d1=%h d2=%h sd=%h c=%h rd=%h; want v=%b r=%b rw=%b d1=%h d2=%h sd=%h c=%h rd=%h (data checked=%b)",
               nm, valid_o, ready_o, reg_write_o, data1_o, data2_o, store_data_o, ALUCtrl_o, rd_addr_o,
               e.vo, e.ro, e.rwo, e.d1, e.d2, e.sd, e.c, e.rd, e.chk);
    end
  endtask
  task automatic model_step(vin_t i);
    bit acc;
    if (!i.rst) q.delete();
    else begin
      acc = i.valid && (q.size() == 0 || i.ready) && !i.flush;
      if (q.size() != 0 && i.ready) void'(q.pop_front());
      else if (q.size() != 0) begin
        q[0].v1 = fwd(q[0].a1, q[0].v1, i);
        q[0].v2 = fwd(q[0].a2, q[0].v2, i);
      end
      if (i.flush) q.delete();
      if (acc)
        q.push_back('{a1: i.a1, a2: i.a2, rd: i.rd, v1: i.d1, v2: i.d2, imm: i.imm,
                      alusrc: i.alusrc, rw: i.rw, ctrl: i.ctrl});
    end
  endtask
  function automatic exp_t model_out(vin_t i);
    exp_t e;
    logic [31:0] o2;
    if (q.size() == 0) return ev(0, 1, 0);
    o2 = fwd(q[0].a2, q[0].v2, i);
    e = ed(1, i.ready, q[0].rw, fwd(q[0].a1, q[0].v1, i), q[0].alusrc ? q[0].imm : o2, o2,
           q[0].ctrl, q[0].rd);
    return e;
  endfunction
  initial begin
    vin_t i;
    exp_t e;
    i = idle(); i.rst = 0; apply(i);
    @(posedge clk); @(negedge clk);
    i = idle(); i.rst = 0; add(i, ed(0, 1, 0, 0, 0, 0, 0, 0));
    i = idle(); i.valid = 1; i.a1 = 1; i.a2 = 2; i.d1 = 5; i.d2 = 7; i.ctrl = 3'b001; i.rd = 4; i.rw = 1;
    add(i, ed(0, 1, 0, 0, 0, 0, 0, 0));
    i = idle(); add(i, ed(1, 1, 1, 5, 7, 7, 3'b001, 4));
    i = idle(); i.valid = 1; i.a1 = 3; i.a2 = 6; i.d1 = 32'h11; i.d2 = 32'h22; i.imm = 32'h30;
    i.alusrc = 1; i.ctrl = 2; i.rd = 5; add(i, ev(0, 1, 0));
    i = idle(); i.ready = 0; i.exrd = 3; i.exrw = 1; i.exd = 32'hAA; i.wbrd = 3; i.wbrw = 1; i.wbd = 32'hBB;
    add(i, ed(1, 0, 0, FWD ? 32'hAA : 32'h11, 32'h30, 32'h22, 2, 5));
    i.exrd = 0; add(i, ed(1, 0, 0, FWD ? 32'hBB : 32'h11, 32'h30, 32'h22, 2, 5));
    i = idle(); i.ready = 0; add(i, ed(1, 0, 0, FWD ? 32'hBB : 32'h11, 32'h30, 32'h22, 2, 5));
    i = idle(); add(i, ed(1, 1, 0, FWD ? 32'hBB : 32'h11, 32'h30, 32'h22, 2, 5));
    i = idle(); i.valid = 1; i.d1 = 32'h99; i.d2 = 32'h77; i.ctrl = 3; i.rd = 7; i.rw = 1;
    add(i, ev(0, 1, 0));
    i = idle(); i.ready = 0; i.exrw = 1; i.exd = 32'h55;
    add(i, ed(1, 0, 1, FWD ? 0 : 32'h99, FWD ? 0 : 32'h77, FWD ? 0 : 32'h77, 3, 7));
    i = idle(); i.valid = 1; i.a1 = 1; i.d1 = 3; i.a2 = 9; i.d2 = 32'h10; i.ctrl = 4; i.rd = 8; i.rw = 1;
    add(i, ed(1, 1, 1, FWD ? 0 : 32'h99, FWD ? 0 : 32'h77, FWD ? 0 : 32'h77, 3, 7));
    i = idle(); i.ready = 0; i.wbrd = 9; i.wbrw = 1; i.wbd = 32'h10;
    add(i, ed(1, 0, 1, 3, 32'h10, 32'h10, 4, 8));
    i.wbd = 32'h20; add(i, ed(1, 0, 1, 3, FWD ? 32'h20 : 32'h10, FWD ? 32'h20 : 32'h10, 4, 8));
    i = idle(); i.ready = 0; add(i, ed(1, 0, 1, 3, FWD ? 32'h20 : 32'h10, FWD ? 32'h20 : 32'h10, 4, 8));
    i = idle(); add(i, ed(1, 1, 1, 3, FWD ? 32'h20 : 32'h10, FWD ? 32'h20 : 32'h10, 4, 8));
    i = idle(); add(i, ev(0, 1, 0));
    i = idle(); i.valid = 1; i.a1 = 2; i.d1 = 32'h44; i.rd = 3; i.rw = 1; i.ctrl = 5;
    add(i, ev(0, 1, 0));
    i = idle(); i.ready = 0; add(i, ed(1, 0, 1, 32'h44, 0, 0, 5, 3));
    i = idle(); i.ready = 0; i.flush = 1; i.valid = 1; i.d1 = 32'h66; i.rd = 9; i.rw = 1;
    add(i, ed(1, 0, 1, 32'h44, 0, 0, 5, 3));
    i = idle(); i.ready = 0; add(i, ev(0, 1, 0));
    i = idle(); i.valid = 1; i.a1 = 1; i.d1 = 32'h12; i.rd = 2; i.rw = 1; add(i, ev(0, 1, 0));
    i = idle(); i.ready = 0; add(i, ed(1, 0, 1, 32'h12, 0, 0, 0, 2));
    i.rst = 0; add(i, ed(1, 0, 1, 32'h12, 0, 0, 0, 2));
    i = idle(); add(i, ed(0, 1, 0, 0, 0, 0, 0, 0));
    i = idle(); add(i, ed(0, 1, 0, 0, 0, 0, 0, 0));
    foreach (tbl[k]) begin
      apply(tbl[k].i);
      #1 check($sformatf("vec%0d", k), tbl[k].e);
      @(posedge clk); @(negedge clk);
    end
    for (int k = 0; k < 1500; k++) begin
      i.rst = (k == 0) ? 1'b0 : 1'($urandom_range(0, 39) != 0);
      i.valid = 1'($urandom_range(0, 1)); i.ready = 1'($urandom_range(0, 3) != 0);
      i.flush = 1'($urandom_range(0, 15) == 0); i.alusrc = 1'($urandom_range(0, 1));
      i.rw = 1'($urandom_range(0, 1)); i.exrw = 1'($urandom_range(0, 1)); i.wbrw = 1'($urandom_range(0, 1));
      i.a1 = 5'($urandom_range(0, 3)); i.a2 = 5'($urandom_range(0, 3)); i.rd = 5'($urandom);
      i.exrd = 5'($urandom_range(0, 3)); i.wbrd = 5'($urandom_range(0, 3));
      i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom; i.exd = $urandom; i.wbd = $urandom;
      i.ctrl = 3'($urandom);
      e = model_out(i);
      apply(i);
      #1 check($sformatf("rand%0d", k), e);
      @(posedge clk);
      model_step(i);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CTRL_W, default 3, ALU control width.
REQ-003 SHALL have parameter RA_W, default 5, register address width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-low.
REQ-006 valid_i / ready_o  input / output  1 / 1  handshake from decode.
REQ-007 rs1_data_i, rs2_data_i, imm_i  input  XLEN  register-file operands and sign-extended immediate.
REQ-008 rs1_addr_i, rs2_addr_i, rd_addr_i  input  RA_W  source and destination register numbers.
REQ-009 alu_src_i  input  1  1 selects imm for operand 2.
REQ-010 ALUCtrl_i  input  CTRL_W  ALU operation code.
REQ-011 reg_write_i  input  1  instruction writes rd.
REQ-012 flush_i  input  1  kill held and incoming instruction.
REQ-013 exmem_rd_i, exmem_regwrite_i, exmem_data_i  input  RA_W/1/XLEN  EX/MEM forwarding source.
REQ-014 memwb_rd_i, memwb_regwrite_i, memwb_data_i  input  RA_W/1/XLEN  MEM/WB forwarding source.
REQ-015 valid_o / ready_i  output / input  1 / 1  handshake to ALU/EX-MEM.
REQ-016 data1_o, data2_o  output  XLEN  ALU operands (feed ALU data1_i/data2_i).
REQ-017 ALUCtrl_o  output  CTRL_W  registered ALU control.
REQ-018 store_data_o  output  XLEN  forwarded rs2 value, regardless of alu_src.
REQ-019 rd_addr_o, reg_write_o  output  RA_W/1  registered destination info.

Function
REQ-020 ready_o SHALL equal !valid_q || ready_i (one-entry skid-free register).
REQ-021 Load on valid_i && ready_o && !flush_i: capture all inputs; valid_q set next cycle; latency exactly 1 cycle.
REQ-022 Transfer out on valid_o && ready_i; with no new load, valid_q clears next cycle.
REQ-023 Held entry (valid_o && !ready_i): all outputs stable except stored rs1/rs2 values, which SHALL be refreshed each cycle with their forwarded values.
REQ-024 Forwarding per operand: EX/MEM match (regwrite, rd==rs, rd!=0) wins over MEM/WB match; else stored value.
REQ-025 Register x0 SHALL never be forwarded; operand from x0 is 0.
REQ-026 data2_o SHALL be stored imm when stored alu_src is 1, else forwarded rs2.
REQ-027 flush_i SHALL clear valid_q next cycle and discard a same-cycle valid_i; flush wins over load and hold.
REQ-028 reg_write_o SHALL be 0 whenever valid_o is 0.
REQ-029 Data outputs when valid_o=0 are don't-care but SHALL not be X after reset.

Reset
REQ-030 rst_i low at a clock edge SHALL zero valid_q and every stored field; outputs read 0 next cycle.
REQ-031 Reset mid-hold SHALL drop the held instruction with no transfer; ready_o=1 after reset.

Configuration
REQ-032 Macro ID_EX_FWD_EN defined: forwarding per REQ-023..025.
REQ-033 Macro absent: operands come straight from stored register-file values, forwarding ports ignored, no refresh on hold.

Structure
REQ-034 XLEN, CTRL_W, RA_W defaults and ALU control encodings SHALL live in shared package riscv_pkg.
REQ-035 Forwarding selection SHALL be sub-module fwd_mux (one instance per source operand).

Verification
REQ-036 Reset: rst_i=0 two cycles -> valid_o=0, ready_o=1, all outputs 0.
REQ-037 Pass-through: rs1=5, rs2=7, ALUCtrl=3'b001, alu_src=0, ready_i=1 -> next cycle valid_o=1, data1_o=5, data2_o=7.
REQ-038 Forward priority: rs1_addr=3, exmem rd=3 data=0xAA, memwb rd=3 data=0xBB, both regwrite -> data1_o=0xAA; exmem rd=0 -> 0xBB.
REQ-039 x0: rs1_addr=0, exmem rd=0 regwrite=1 data=0x55 -> data1_o=0.
REQ-040 Backpressure: ready_i=0 three cycles with memwb updating rs2 value 0x10->0x20 -> outputs held, store_data_o follows 0x20, ready_o=0, single transfer when ready_i=1.
REQ-041 Flush: flush_i=1 with valid_i=1 and entry held -> next cycle valid_o=0, reg_write_o=0.
